// File: rtl/cond_status_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cond_status_unit_pkg
//  Description : Shared constants for the condition/status unit: ARM
//                condition codes, status-register bit positions and the
//                default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cond_status_unit_pkg;

    // Default datapath width
    localparam int c_DATA_W = 32;

    // Status register bit positions, SR = {Z,C,N,V}
    localparam int c_SR_Z = 3;
    localparam int c_SR_C = 2;
    localparam int c_SR_N = 1;
    localparam int c_SR_V = 0;

    // ARM condition field encodings
    localparam logic [3:0] c_EQ = 4'h0;
    localparam logic [3:0] c_NE = 4'h1;
    localparam logic [3:0] c_CS = 4'h2;
    localparam logic [3:0] c_CC = 4'h3;
    localparam logic [3:0] c_MI = 4'h4;
    localparam logic [3:0] c_PL = 4'h5;
    localparam logic [3:0] c_VS = 4'h6;
    localparam logic [3:0] c_VC = 4'h7;
    localparam logic [3:0] c_HI = 4'h8;
    localparam logic [3:0] c_LS = 4'h9;
    localparam logic [3:0] c_GE = 4'hA;
    localparam logic [3:0] c_LT = 4'hB;
    localparam logic [3:0] c_GT = 4'hC;
    localparam logic [3:0] c_LE = 4'hD;
    localparam logic [3:0] c_AL = 4'hE;
    localparam logic [3:0] c_NV = 4'hF;

endpackage : cond_status_unit_pkg
`default_nettype wire

// File: rtl/cond_status_unit_cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : Purely combinational ARM condition evaluator.
//  Ports       : i_cond [3:0] - condition field
//                i_sr   [3:0] - status flags {Z,C,N,V}
//                o_pass       - condition holds on i_sr
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import cond_status_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_sr,
    output logic       o_pass
);

    logic w_z;
    logic w_c;
    logic w_n;
    logic w_v;

    assign w_z = i_sr[c_SR_Z];
    assign w_c = i_sr[c_SR_C];
    assign w_n = i_sr[c_SR_N];
    assign w_v = i_sr[c_SR_V];

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            c_EQ:    o_pass = w_z;
            c_NE:    o_pass = !w_z;
            c_CS:    o_pass = w_c;
            c_CC:    o_pass = !w_c;
            c_MI:    o_pass = w_n;
            c_PL:    o_pass = !w_n;
            c_VS:    o_pass = w_v;
            c_VC:    o_pass = !w_v;
            c_HI:    o_pass = w_c && !w_z;
            c_LS:    o_pass = !w_c || w_z;
            c_GE:    o_pass = (w_n == w_v);
            c_LT:    o_pass = (w_n != w_v);
            c_GT:    o_pass = !w_z && (w_n == w_v);
            c_LE:    o_pass = w_z || (w_n != w_v);
            c_AL:    o_pass = 1'b1;
            // NV is reserved: never executes
            default: o_pass = 1'b0;
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_status_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cond_status_unit
//  Description : Back end of the execute stage. Holds the committed status
//                register {Z,C,N,V}, evaluates the EX instruction's condition
//                against it, registers the EX/MEM pipeline fields (turning
//                condition-failed instructions into bubbles) and keeps a
//                saturating count of squashed instructions.
//  Ports       : clk, rst_n                      - clock, async active-low reset
//                ex_*, alu_out, alu_sr           - EX stage instruction / ALU
//                stall, flush                    - pipeline control
//                sr_q, sr_carry                  - committed flags, carry to ALU
//                cond_pass                       - EX instruction will execute
//                mem_*                           - EX/MEM pipeline register
//                squash_cnt                      - condition-failed count
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_status_unit
    import cond_status_unit_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [3:0]        ex_cond,
    input  logic              ex_s,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_sr,
    input  logic [3:0]        ex_dest,
    input  logic              ex_wb_en,
    input  logic              ex_mem_r,
    input  logic              ex_mem_w,
    input  logic [DATA_W-1:0] ex_st_val,
    input  logic              stall,
    input  logic              flush,
    output logic [3:0]        sr_q,
    output logic              sr_carry,
    output logic              cond_pass,
    output logic              mem_valid,
    output logic              mem_wb_en,
    output logic              mem_mem_r,
    output logic              mem_mem_w,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_st_val,
    output logic [3:0]        mem_dest,
    output logic [CNT_W-1:0]  squash_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]        r_sr;
    logic              r_mem_valid;
    logic              r_mem_wb_en;
    logic              r_mem_mem_r;
    logic              r_mem_mem_w;
    logic [DATA_W-1:0] r_mem_alu_out;
    logic [DATA_W-1:0] r_mem_st_val;
    logic [3:0]        r_mem_dest;
    logic [CNT_W-1:0]  r_squash_cnt;

    logic w_cond_true;
    logic w_issue;
    logic w_squash;

    // Condition is judged on the committed flags, i.e. before this
    // instruction's own flag update lands.
    cond_check u_cond_check (
        .i_cond (ex_cond),
        .i_sr   (r_sr),
        .o_pass (w_cond_true)
    );

    assign w_issue  = ex_valid && w_cond_true;
    assign w_squash = ex_valid && !w_cond_true;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr          <= 4'h0;
            r_mem_valid   <= 1'b0;
            r_mem_wb_en   <= 1'b0;
            r_mem_mem_r   <= 1'b0;
            r_mem_mem_w   <= 1'b0;
            r_mem_alu_out <= '0;
            r_mem_st_val  <= '0;
            r_mem_dest    <= 4'h0;
            r_squash_cnt  <= '0;
        end else if (flush) begin
            // Killed instruction: controls cleared, data held, flags untouched
            r_mem_valid <= 1'b0;
            r_mem_wb_en <= 1'b0;
            r_mem_mem_r <= 1'b0;
            r_mem_mem_w <= 1'b0;
        end else if (!stall) begin
            if (w_issue) begin
                r_mem_valid   <= 1'b1;
                r_mem_wb_en   <= ex_wb_en;
                r_mem_mem_r   <= ex_mem_r;
                r_mem_mem_w   <= ex_mem_w;
                r_mem_alu_out <= alu_out;
                r_mem_st_val  <= ex_st_val;
                r_mem_dest    <= ex_dest;
                if (ex_s) begin
                    r_sr <= alu_sr;
                end
            end else begin
                // Condition-failed or empty slot becomes a bubble
                r_mem_valid <= 1'b0;
                r_mem_wb_en <= 1'b0;
                r_mem_mem_r <= 1'b0;
                r_mem_mem_w <= 1'b0;
                if (w_squash && (r_squash_cnt != c_CNT_MAX)) begin
                    r_squash_cnt <= r_squash_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign sr_q        = r_sr;
    assign sr_carry    = r_sr[c_SR_C];
    assign cond_pass   = w_issue;
    assign mem_valid   = r_mem_valid;
    assign mem_wb_en   = r_mem_wb_en;
    assign mem_mem_r   = r_mem_mem_r;
    assign mem_mem_w   = r_mem_mem_w;
    assign mem_alu_out = r_mem_alu_out;
    assign mem_st_val  = r_mem_st_val;
    assign mem_dest    = r_mem_dest;
    assign squash_cnt  = r_squash_cnt;

endmodule : cond_status_unit
`default_nettype wire
